optical_8x8_route_check: RTL
============================

// Module: optical_8x8_route_check
// PURPOSE
//  Receive-side checker for the 8x8 optical switch controller: takes the 20-bit Benes switch
//  grant produced by optical_8x8_top and walks the 5-stage x 4-switch fabric, one stage per clock.
//  Recovers the input-port -> output-port permutation and compares it with the request that produced it.
//  Sits beside the controller, between grant output and switch driver; flags bad grants before they reach the optics.
// PARAMETERS
//  P_BAR        1'b0  grant bit value for BAR (straight) switch state
//  P_CROSS      1'b1  grant bit value for CROSS (swap) switch state
//  P_DSTWIDTH   3     bits per destination field
//  P_PORTNUM    8     ports; only 8 is supported (elaboration $error otherwise)
//  P_SWITCHNUM  4     2x2 switches per stage
//  P_STAGENUM   5     Benes stages (2*log2(P_PORTNUM)-1)
// PORTS
//  i_clk          in   1   clock
//  i_rst_n        in   1   asynchronous active-low reset
//  i_8x8_req      in   24  field k = bits[3k+2:3k] = destination of input port k
//  i_8x8_valid    in   1   1-cycle strobe; latches i_8x8_req into the request register
//  i_grant_8x8    in   20  bit (stage*4 + sw) = state of switch sw in stage 0..4
//  i_grant_valid  in   1   1-cycle strobe; starts a check when idle
//  o_route_8x8    out  24  recovered destination per input port, same packing as i_8x8_req
//  o_route_valid  out  1   1-cycle pulse, o_route_8x8/o_match/o_no_req valid
//  o_match        out  1   1 = recovered route equals snapshotted request
//  o_no_req       out  1   1 = no request latched since reset when the check started (o_match forced 0)
//  o_busy         out  1   check in flight; grants ignored
//  o_drop_cnt     out  8   saturating count of grants dropped while busy
// BEHAVIOUR
//  Reset: all outputs 0, request register 0, req_seen 0, FSM IDLE, in-flight check discarded (no pulse).
//  Fabric: switch s of a stage joins lanes 2s, 2s+1; BAR passes straight, CROSS swaps them.
//  Inter-stage wiring on lane index {a,b,c}: 0->1 {c,a,b}; 1->2 {a,c,b}; 2->3 {a,c,b}; 3->4 {b,c,a}.
//  All-BAR grant is the identity.
//  Datapath: 8 tag lanes x 3 bits hold the source port id. Load sets lane i = i.
//  Each PROP cycle applies stage stg's switches, then the wiring after it (none after stage 4).
//  FSM IDLE -> PROP -> DONE -> IDLE.
//   IDLE: on i_grant_valid, register the grant, load tags, stg=0, and snapshot the request register (r_exp).
//    Snapshot no_req = !req_seen. Raise o_busy. Go to PROP.
//   PROP: 5 cycles, stg 0..4; on stg==4 go to DONE. stg is a 3-bit counter and never wraps past 4.
//   DONE: invert tags (lane o holding src s => route[s]=o); register o_route_8x8.
//    o_match = (route==r_exp) & !no_req; pulse o_route_valid; drop o_busy; go to IDLE.
//  Latency: o_route_valid is high in the cycle after the 7th rising edge counting the sampling edge (T+6 edges after T).
//   A new grant is accepted in that same cycle: 1 check per 7 cycles max.
//  o_route_8x8/o_match/o_no_req hold until the next DONE; o_route_valid is 0 except for its pulse.
//  i_8x8_valid is accepted in any state. r_exp is snapshotted, so a mid-check request never affects the result.
//  i_8x8_valid and i_grant_valid in the same IDLE cycle: the new request is used (bypass into r_exp).
//  i_grant_valid while busy (PROP/DONE): grant ignored, o_drop_cnt++ saturating at 8'hFF.
//  No route_valid pulse for a dropped grant.
// STRUCTURE
//  Shared package optical_8x8_pkg: P_BAR/P_CROSS constants, stage/switch counts, the wiring
//   function lane_wire(stage, lane), and a grant bit-index function. optical_8x8_top uses the same functions.
//  Sub-module optical_benes_stage: combinational 8-lane tag stage (grant slice + stage index -> next tags), one instance.
//   The FSM selects the grant slice by stg.
// TESTING
//  1 req {7,6,5,4,3,2,1,0} (port7..port0), grant 20'h00000 -> route {7,6,5,4,3,2,1,0}, match=1, route_valid 6 edges after grant.
//  2 req {3,2,1,0,7,6,5,4}, grant 20'hFFFFF -> route = port^4 = {3,2,1,0,7,6,5,4}, match=1.
//  3 req {7,6,5,0,3,2,1,4}, grant 20'h00100 (stage2 sw0 CROSS) -> route {7,6,5,0,3,2,1,4}, match=1;
//    same grant with req identity -> match=0, route unchanged.
//  4 grant pulse 2 cycles after an accepted grant, and again at cycle 4 -> exactly one route_valid, drop_cnt=2;
//    then 300 busy grants -> drop_cnt saturates at 255.
//  5 i_rst_n low during PROP (stg=2) -> no route_valid, busy=0, drop_cnt=0;
//    first grant after reset with no req -> no_req=1, match=0.
//  6 i_8x8_valid with new req in PROP -> result compares against the old snapshot;
//    req+grant same IDLE cycle -> new req used.

Source files
------------

// File: rtl/optical_8x8_pkg.sv
// Shared definitions for the 8x8 Benes optical switch controller and its route checker:
// switch-state encodings, fabric dimensions, FSM states and the fabric wiring helpers.
package optical_8x8_pkg;

    localparam logic C_BAR       = 1'b0;
    localparam logic C_CROSS     = 1'b1;
    localparam int   C_DSTWIDTH  = 3;
    localparam int   C_PORTNUM   = 8;
    localparam int   C_SWITCHNUM = 4;
    localparam int   C_STAGENUM  = 5;
    localparam int   C_TAGS_W    = C_PORTNUM * C_DSTWIDTH;
    localparam int   C_GRANT_W   = C_STAGENUM * C_SWITCHNUM;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PROP = 2'b01,
        ST_DONE = 2'b10
    } rc_state_e;

    // Lane reached after the inter-stage wiring that follows 'stage'; lane bits are {a,b,c}.
    function automatic logic [2:0] lane_wire(input logic [2:0] stage, input logic [2:0] lane);
        logic [2:0] w;
        case (stage)
            3'd0:       w = {lane[0], lane[2], lane[1]};
            3'd1, 3'd2: w = {lane[2], lane[0], lane[1]};
            3'd3:       w = {lane[1], lane[0], lane[2]};
            default:    w = lane;
        endcase
        return w;
    endfunction

    // Grant bit of switch 'sw' in 'stage' (stage*4 + sw).
    function automatic logic [4:0] grant_idx(input logic [2:0] stage, input logic [1:0] sw);
        return {stage, sw};
    endfunction

endpackage

// File: rtl/optical_8x8_route_check_if.sv
// Request/grant inputs and route-check results exchanged with optical_8x8_route_check.
interface optical_8x8_route_check_if;

    logic [23:0] i_8x8_req;
    logic        i_8x8_valid;
    logic [19:0] i_grant_8x8;
    logic        i_grant_valid;
    logic [23:0] o_route_8x8;
    logic        o_route_valid;
    logic        o_match;
    logic        o_no_req;
    logic        o_busy;
    logic [7:0]  o_drop_cnt;

    modport master (
        output i_8x8_req, i_8x8_valid, i_grant_8x8, i_grant_valid,
        input  o_route_8x8, o_route_valid, o_match, o_no_req, o_busy, o_drop_cnt
    );

    modport slave (
        input  i_8x8_req, i_8x8_valid, i_grant_8x8, i_grant_valid,
        output o_route_8x8, o_route_valid, o_match, o_no_req, o_busy, o_drop_cnt
    );

endinterface

// File: rtl/optical_benes_stage.sv
// One Benes stage on 8 source-id tag lanes: the four 2x2 switches, then the wiring to the next stage.
module optical_benes_stage
    import optical_8x8_pkg::*;
#(
    parameter logic P_CROSS = C_CROSS
) (
    input  logic [C_TAGS_W-1:0]    tags_i,
    input  logic [C_SWITCHNUM-1:0] sw_i,
    input  logic [2:0]             stage_i,
    output logic [C_TAGS_W-1:0]    tags_o
);

    logic [C_TAGS_W-1:0] swapped_s;

    // Switch layer: switch s owns lanes 2s and 2s+1.
    always_comb begin
        swapped_s = tags_i;
        for (int s = 0; s < C_SWITCHNUM; s++) begin
            if (sw_i[s] == P_CROSS) begin
                swapped_s[(2*s)*C_DSTWIDTH +: C_DSTWIDTH]   = tags_i[(2*s+1)*C_DSTWIDTH +: C_DSTWIDTH];
                swapped_s[(2*s+1)*C_DSTWIDTH +: C_DSTWIDTH] = tags_i[(2*s)*C_DSTWIDTH +: C_DSTWIDTH];
            end else begin
                swapped_s[(2*s)*C_DSTWIDTH +: C_DSTWIDTH]   = tags_i[(2*s)*C_DSTWIDTH +: C_DSTWIDTH];
                swapped_s[(2*s+1)*C_DSTWIDTH +: C_DSTWIDTH] = tags_i[(2*s+1)*C_DSTWIDTH +: C_DSTWIDTH];
            end
        end
    end

    // Inter-stage wiring: the wiring is a permutation, so every output lane is written once.
    always_comb begin
        tags_o = '0;
        for (int l = 0; l < C_PORTNUM; l++) begin
            tags_o[lane_wire(stage_i, 3'(l))*C_DSTWIDTH +: C_DSTWIDTH] = swapped_s[l*C_DSTWIDTH +: C_DSTWIDTH];
        end
    end

endmodule

// File: rtl/optical_8x8_route_check.sv
// Walks a 20-bit Benes grant through the 5-stage fabric one stage per clock, recovers the
// port permutation and compares it with the request snapshotted when the check started.
module optical_8x8_route_check
    import optical_8x8_pkg::*;
#(
    parameter logic P_BAR       = C_BAR,
    parameter logic P_CROSS     = C_CROSS,
    parameter int   P_DSTWIDTH  = C_DSTWIDTH,
    parameter int   P_PORTNUM   = C_PORTNUM,
    parameter int   P_SWITCHNUM = C_SWITCHNUM,
    parameter int   P_STAGENUM  = C_STAGENUM
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    optical_8x8_route_check_if.slave  bus
);

    if ((P_PORTNUM != 8) || (P_DSTWIDTH != 3) || (P_SWITCHNUM != 4) || (P_STAGENUM != 5)
        || (P_BAR == P_CROSS)) begin : g_bad_cfg
        $error("optical_8x8_route_check: only the 8-port, 5-stage fabric is supported");
    end

    rc_state_e               state_q, state_d;
    logic [2:0]              stg_q, stg_d;
    logic [C_TAGS_W-1:0]     tags_q, tags_d;
    logic [C_GRANT_W-1:0]    grant_q, grant_d;
    logic [C_TAGS_W-1:0]     req_q, req_d;
    logic                    req_seen_q, req_seen_d;
    logic [C_TAGS_W-1:0]     r_exp_q, r_exp_d;
    logic                    snap_no_req_q, snap_no_req_d;
    logic [C_TAGS_W-1:0]     route_q, route_d;
    logic                    route_valid_q, route_valid_d;
    logic                    match_q, match_d;
    logic                    no_req_q, no_req_d;
    logic                    busy_q, busy_d;
    logic [7:0]              drop_q, drop_d;

    logic [C_SWITCHNUM-1:0]  grant_slice_s;
    logic [C_TAGS_W-1:0]     stage_tags_s;
    logic [C_TAGS_W-1:0]     tags_init_s;
    logic [C_TAGS_W-1:0]     route_s;

    // Switch states of the stage currently being propagated.
    always_comb begin
        grant_slice_s = '0;
        for (int sw = 0; sw < C_SWITCHNUM; sw++) begin
            grant_slice_s[sw] = grant_q[grant_idx(stg_q, 2'(sw))];
        end
    end

    // Load value: every lane carries its own port number as source tag.
    always_comb begin
        tags_init_s = '0;
        for (int l = 0; l < C_PORTNUM; l++) begin
            tags_init_s[l*C_DSTWIDTH +: C_DSTWIDTH] = 3'(l);
        end
    end

    // Invert the final lane map: output lane o holding source s means route[s] = o.
    always_comb begin
        route_s = '0;
        for (int o = 0; o < C_PORTNUM; o++) begin
            route_s[tags_q[o*C_DSTWIDTH +: C_DSTWIDTH]*C_DSTWIDTH +: C_DSTWIDTH] = 3'(o);
        end
    end

    optical_benes_stage #(
        .P_CROSS (P_CROSS)
    ) u_stage (
        .tags_i  (tags_q),
        .sw_i    (grant_slice_s),
        .stage_i (stg_q),
        .tags_o  (stage_tags_s)
    );

    // Next-state logic: request capture, drop counting and the IDLE/PROP/DONE sequence.
    always_comb begin
        state_d       = state_q;
        stg_d         = stg_q;
        tags_d        = tags_q;
        grant_d       = grant_q;
        req_d         = req_q;
        req_seen_d    = req_seen_q;
        r_exp_d       = r_exp_q;
        snap_no_req_d = snap_no_req_q;
        route_d       = route_q;
        route_valid_d = 1'b0;
        match_d       = match_q;
        no_req_d      = no_req_q;
        busy_d        = busy_q;
        drop_d        = drop_q;

        if (bus.i_8x8_valid) begin
            req_d      = bus.i_8x8_req;
            req_seen_d = 1'b1;
        end else begin
            req_d      = req_q;
            req_seen_d = req_seen_q;
        end

        if (bus.i_grant_valid && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_grant_valid) begin
                    grant_d = bus.i_grant_8x8;
                    tags_d  = tags_init_s;
                    stg_d   = 3'd0;
                    // A request arriving in the same cycle bypasses into the snapshot.
                    if (bus.i_8x8_valid) begin
                        r_exp_d = bus.i_8x8_req;
                    end else begin
                        r_exp_d = req_q;
                    end
                    snap_no_req_d = !(req_seen_q || bus.i_8x8_valid);
                    busy_d        = 1'b1;
                    state_d       = ST_PROP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROP: begin
                tags_d = stage_tags_s;
                if (stg_q == 3'd4) begin
                    state_d = ST_DONE;
                end else begin
                    stg_d = stg_q + 3'd1;
                end
            end
            ST_DONE: begin
                route_d       = route_s;
                match_d       = (route_s == r_exp_q) && !snap_no_req_q;
                no_req_d      = snap_no_req_q;
                route_valid_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            stg_q         <= 3'd0;
            tags_q        <= '0;
            grant_q       <= '0;
            req_q         <= '0;
            req_seen_q    <= 1'b0;
            r_exp_q       <= '0;
            snap_no_req_q <= 1'b0;
            route_q       <= '0;
            route_valid_q <= 1'b0;
            match_q       <= 1'b0;
            no_req_q      <= 1'b0;
            busy_q        <= 1'b0;
            drop_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            stg_q         <= stg_d;
            tags_q        <= tags_d;
            grant_q       <= grant_d;
            req_q         <= req_d;
            req_seen_q    <= req_seen_d;
            r_exp_q       <= r_exp_d;
            snap_no_req_q <= snap_no_req_d;
            route_q       <= route_d;
            route_valid_q <= route_valid_d;
            match_q       <= match_d;
            no_req_q      <= no_req_d;
            busy_q        <= busy_d;
            drop_q        <= drop_d;
        end
    end

    assign bus.o_route_8x8   = route_q;
    assign bus.o_route_valid = route_valid_q;
    assign bus.o_match       = match_q;
    assign bus.o_no_req      = no_req_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_drop_cnt    = drop_q;

endmodule
